// File: rtl/display_mux_7seg_if.sv
// display_mux_7seg_if: bundle between the datapath/status logic and the
// 7-segment scanner.
//   master : producer side. It drives en/carga/entrada/punto and observes the
//            display pins and status.
//   slave  : the scanner. It samples the controls and drives
//            salida/dp/anodo/pendiente/fin_cuadro.
// DIGITOS must match the DIGITOS of the attached display_mux_7seg.
interface display_mux_7seg_if #(
  parameter int DIGITOS = 4
) ();
  logic                   en;
  logic                   carga;
  logic [4*DIGITOS-1:0]   entrada;
  logic [DIGITOS-1:0]     punto;
  logic [6:0]             salida;
  logic                   dp;
  logic [DIGITOS-1:0]     anodo;
  logic                   pendiente;
  logic                   fin_cuadro;

  modport master (
    output en, carga, entrada, punto,
    input  salida, dp, anodo, pendiente, fin_cuadro
  );

  modport slave (
    input  en, carga, entrada, punto,
    output salida, dp, anodo, pendiente, fin_cuadro
  );
endinterface

// File: rtl/display_mux_7seg.sv
// display_mux_7seg: time-multiplexed driver for a common-anode 7-segment
// display.
// - Scans one digit per DIV clocks.
// - Decodes each hex nibble to active-low segments.
// - Double-buffers new values: a load lands in a shadow register and is
//   copied to the active register only when the digit index wraps, so a
//   frame never mixes old and new digits.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset.
//   bus (slave)    : inputs
//                      en        - low blanks the display and freezes the scan.
//                      carga     - load strobe.
//                      entrada   - one nibble per digit; digit 0 is the LSB.
//                      punto     - decimal-point request per digit.
//                    outputs
//                      salida    - segments {g..a}, active-low, registered.
//                      dp        - decimal point, active-low, registered.
//                      anodo     - digit select, active-low one-hot, registered.
//                      pendiente - the shadow holds an uncommitted value.
//                      fin_cuadro- high for the one cycle in which the index
//                                  wraps DIGITOS-1 -> 0.
//
// Optional build macro DISPLAY_MUX_LEADING_ZERO_BLANK_EN blanks leading zero
// digits. Digit 0 is never blanked. The blank decision uses the active
// register. When blanking applies, anodo and dp are unaffected.

// Per-digit decoder. One instance exists per digit; the top selects the
// lit one.
module display_mux_7seg_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] dec;

  always_comb begin
    dec = 7'b1111111;
    case (nib)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0011000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b0100111;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'b1111111;
    endcase
  end

  assign seg = blank ? 7'b1111111 : dec;
endmodule

module display_mux_7seg #(
  parameter int DIGITOS = 4,
  parameter int DIV     = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  display_mux_7seg_if.slave  bus
);
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITOS-1:0][3:0]  sh_nib, act_nib;
  logic [DIGITOS-1:0]       sh_pt, act_pt;
  logic                     pend;
  logic                     tick, wrap;
  logic [DIGITOS-1:0]       blank;
  logic [DIGITOS-1:0][6:0]  seg;

  // A tick advances the digit. It can only occur while enabled, so en=0
  // also suppresses wrap, fin_cuadro and commit.
  assign tick = bus.en && (cnt == CW'(DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITOS - 1));

  assign bus.fin_cuadro = wrap;
  assign bus.pendiente  = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (bus.en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= wrap ? '0 : idx + IW'(1);
    end
  end

  // When a load and a wrap coincide, the old shadow commits. The new data
  // then stays pending until the next wrap, so carga has priority on pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_nib  <= '0;
      sh_pt   <= '0;
      act_nib <= '0;
      act_pt  <= '0;
      pend    <= 1'b0;
    end else begin
      if (wrap && pend) begin
        act_nib <= sh_nib;
        act_pt  <= sh_pt;
      end
      if (bus.carga) begin
        sh_nib <= bus.entrada;
        sh_pt  <= bus.punto;
        pend   <= 1'b1;
      end else if (wrap) begin
        pend   <= 1'b0;
      end
    end
  end

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  // zup[k]: digit k and every digit above it are zero.
  logic [DIGITOS:1] zup;
  assign zup[DIGITOS] = 1'b1;
  for (genvar k = 0; k < DIGITOS; k++) begin : g_blank
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_up
      assign zup[k]   = zup[k+1] & (act_nib[k] == 4'd0);
      assign blank[k] = zup[k];
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITOS; k++) begin : g_lane
    display_mux_7seg_lane u_lane (
      .nib   (act_nib[k]),
      .blank (blank[k]),
      .seg   (seg[k])
    );
  end

  // One registered stage from the current idx and active register.
  // Outputs therefore trail an idx change by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.anodo  <= '1;
      bus.salida <= 7'b1111111;
      bus.dp     <= 1'b1;
    end else if (!bus.en) begin
      bus.anodo  <= '1;
      bus.salida <= 7'b1111111;
      bus.dp     <= 1'b1;
    end else begin
      bus.anodo  <= ~(DIGITOS'(1) << idx);
      bus.salida <= seg[idx];
      bus.dp     <= ~act_pt[idx];
    end
  end
endmodule
